// File: rtl/header_loader.sv
// header_loader: frames an 80-byte block header from a byte stream and drives
// the block-storage write port (o_data_en / o_data / o_data_sel).
// Optional macro HEADER_LOADER_CHECKSUM_EN adds a trailing XOR checksum byte,
// a CHECK state and the chk_err output.
module header_loader #(
  parameter int HEADER_BYTES = 80,
  parameter int SEL_WIDTH    = 7
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic                 rx_ready,
  input  logic                 frame_start,
  input  logic                 miner_busy,
  output logic                 o_data_en,
  output logic [7:0]           o_data,
  output logic [SEL_WIDTH-1:0] o_data_sel,
  output logic                 header_valid,
  output logic                 load_active,
  output logic                 err_overrun
`ifdef HEADER_LOADER_CHECKSUM_EN
  ,
  output logic                 chk_err
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    DONE
`ifdef HEADER_LOADER_CHECKSUM_EN
    ,
    CHECK
`endif
  } state_t;

  localparam logic [SEL_WIDTH-1:0] LAST = SEL_WIDTH'(HEADER_BYTES - 1);

  state_t               state, state_next;
  logic [SEL_WIDTH-1:0] count;
  logic                 accepting;
  logic                 xfer;
`ifdef HEADER_LOADER_CHECKSUM_EN
  logic [7:0]           acc;
`endif

  // State register.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state decode and handshake; frame_start overrides every state.
  always_comb begin
    state_next = state;
`ifdef HEADER_LOADER_CHECKSUM_EN
    accepting  = (state == LOAD) || (state == CHECK);
`else
    accepting  = (state == LOAD);
`endif
    rx_ready   = accepting && !miner_busy && !frame_start;
    xfer       = rx_valid && rx_ready;
    if (frame_start) begin
      state_next = LOAD;
    end else begin
      case (state)
        LOAD: begin
          if (xfer && (count == LAST)) begin
`ifdef HEADER_LOADER_CHECKSUM_EN
            state_next = CHECK;
`else
            state_next = DONE;
`endif
          end
        end
`ifdef HEADER_LOADER_CHECKSUM_EN
        CHECK: begin
          if (xfer) state_next = (rx_data == acc) ? DONE : IDLE;
        end
`endif
        default: ;
      endcase
    end
  end

  assign load_active = (state == LOAD);

  // Write-port registers, byte counter and status flags.
  // header_valid is registered off the DONE state so it rises one cycle after
  // the final transfer, together with completion of the last storage write.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count        <= '0;
      o_data_en    <= 1'b0;
      o_data       <= '0;
      o_data_sel   <= '0;
      header_valid <= 1'b0;
      err_overrun  <= 1'b0;
`ifdef HEADER_LOADER_CHECKSUM_EN
      acc          <= '0;
      chk_err      <= 1'b0;
`endif
    end else begin
      o_data_en <= 1'b0;
      if (frame_start) begin
        count        <= '0;
        header_valid <= 1'b0;
        err_overrun  <= 1'b0;
`ifdef HEADER_LOADER_CHECKSUM_EN
        acc          <= '0;
        chk_err      <= 1'b0;
`endif
      end else begin
        if ((state == LOAD) && xfer) begin
          o_data     <= rx_data;
          o_data_sel <= count;
          o_data_en  <= 1'b1;
          if (count != LAST) count <= count + 1'b1;
`ifdef HEADER_LOADER_CHECKSUM_EN
          acc <= acc ^ rx_data;
`endif
        end
        if (state == DONE) begin
          header_valid <= 1'b1;
          if (rx_valid) err_overrun <= 1'b1;
        end
`ifdef HEADER_LOADER_CHECKSUM_EN
        if ((state == CHECK) && xfer && (rx_data != acc)) chk_err <= 1'b1;
`endif
      end
    end
  end

endmodule

// File: doc/header_loader.md
Name: header_loader

Overview:
- Upstream feeder for PD_block_storage: takes a byte stream carrying an 80-byte Bitcoin block header and drives the storage write port.
- The write port is i_data_en, i_data and i_data_sel; i_data_sel is the byte index, 0..79.
- Counts and frames the header, applies backpressure while the hash core is busy, and flags completion or overrun to the control unit.

Parameters:
- HEADER_BYTES, 80, number of header bytes per frame.
- SEL_WIDTH, 7, width of the byte-index output; must satisfy 2**SEL_WIDTH >= HEADER_BYTES.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- n_rst  input  1  reset, asynchronous, active-low.
- rx_data  input  8  incoming header byte.
- rx_valid  input  1  rx_data valid this cycle.
- rx_ready  output  1  loader accepts a byte this cycle; a transfer occurs when rx_valid && rx_ready.
- frame_start  input  1  single-cycle pulse that begins a new header frame.
- miner_busy  input  1  hash core is reading block storage; stalls loading.
- o_data_en  output  1  to block storage i_data_en.
- o_data  output  8  to block storage i_data.
- o_data_sel  output  SEL_WIDTH  to block storage i_data_sel.
- header_valid  output  1  full header written; level signal.
- load_active  output  1  high in LOAD state.
- err_overrun  output  1  sticky; a byte was offered after the header completed.

Behaviour:
- Reset values (asynchronous on n_rst low): state=IDLE, count=0, rx_ready=0, o_data_en=0, o_data=0, o_data_sel=0, header_valid=0, load_active=0, err_overrun=0.
- States: IDLE, LOAD, DONE.
- IDLE:
  - rx_ready=0; rx_valid is ignored.
  - frame_start -> LOAD.
- LOAD:
  - rx_ready = !miner_busy && !frame_start (combinational).
  - On transfer: register o_data=rx_data, o_data_sel=count, o_data_en=1 for exactly one cycle, then count++.
  - o_data_en is 0 in any cycle following a non-transfer cycle.
  - Transfer with count==HEADER_BYTES-1 -> DONE.
- DONE:
  - header_valid=1, rx_ready=0.
  - rx_valid high in DONE sets err_overrun (sticky); the byte is discarded.
- frame_start in any state:
  - next state LOAD, count=0, header_valid=0, err_overrun=0.
  - A byte presented in the same cycle is not accepted, because rx_ready is forced low.
  - Mid-LOAD restart discards the partial frame; already-written storage bytes are left stale and are overwritten by the new frame.
- Latency: a transfer at edge k gives o_data_en=1 in cycle k..k+1; storage captures at edge k+1.
- header_valid rises on the edge after the byte-79 write is issued. It therefore rises together with the last o_data_en cycle's completion, i.e. one cycle after the final transfer edge.
- miner_busy asserted mid-LOAD:
  - rx_ready drops the same cycle.
  - count holds.
  - A write already registered still completes, since o_data_en was issued before the stall.
- count never exceeds HEADER_BYTES-1; there is no wrap-around. A new frame_start is required to reload.
- Back-to-back transfers (rx_valid held high, miner_busy low) give one byte per cycle, so a full header loads in 80 consecutive cycles.

Optional Feature:
- Macro: HEADER_LOADER_CHECKSUM_EN.
- Defined:
  - Adds state CHECK between LOAD and DONE, plus output chk_err (1 bit, reset 0).
  - The loader XOR-accumulates all 80 accepted bytes.
  - In CHECK, rx_ready follows the LOAD rule and the 81st byte is accepted as a checksum. This byte is not written to storage (o_data_en stays 0).
  - Checksum equal to the accumulator -> DONE with header_valid=1.
  - Mismatch -> chk_err=1 (sticky until frame_start) and return to IDLE with header_valid=0.
- Not defined: no CHECK state and no chk_err port; LOAD goes directly to DONE after byte 79.

Test Plan:
- Reset mid-stream:
  - Stimulus: assert n_rst low asynchronously during LOAD at count=37.
  - Required: all outputs 0 immediately, without waiting for a clock edge; state IDLE; rx_ready=0.
- Full frame:
  - Stimulus: frame_start, then bytes 0x00..0x4F on consecutive cycles with miner_busy=0.
  - Required: 80 o_data_en pulses with o_data_sel==o_data==i.
  - Required: header_valid=1 one cycle after the last transfer.
  - Required: storage chunk_1[i]=i and chunk_2[j]=64+j.
- Stall:
  - Stimulus: miner_busy=1 for 5 cycles at count=20 while rx_valid=1.
  - Required: rx_ready=0 and no o_data_en during the stall.
  - Required: loading resumes at o_data_sel=20 with no byte lost or duplicated.
- Restart:
  - Stimulus: frame_start at count=50, simultaneous with rx_valid=1 and rx_data=0xAA.
  - Required: 0xAA is not accepted.
  - Required: next transfer has o_data_sel=0; header_valid stays 0 until 80 new bytes arrive.
- Overrun:
  - Stimulus: rx_valid=1 in DONE.
  - Required: err_overrun=1, no write, header_valid stays 1.
  - Required: the next frame_start clears both err_overrun and header_valid.
- Checksum (HEADER_LOADER_CHECKSUM_EN only):
  - Stimulus: bytes 0x00..0x4F followed by checksum 0x00 (the XOR of 0x00..0x4F).
  - Required: DONE with header_valid=1.
  - Stimulus: repeat the frame with checksum 0x01.
  - Required: chk_err=1, IDLE, header_valid=0.
